// File: rtl/img_rsz_blk_acc_pkg.sv
// ImgRszPkg: shared sizes and types for the image resizer block accumulator.
// Holds the source/resized geometry, the derived block dimensions, index
// widths and the block sum type.
package ImgRszPkg;

  // Index width that never collapses to zero bits for a size of 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PXL_W = 8;
  localparam int SRC_W = 64;
  localparam int SRC_H = 48;

  localparam int RSZ_IMG_WIDTH_SIZE   = 16;
  localparam int RSZ_IMG_HEIGHT_SIZE  = 12;
  localparam int RSZ_IMG_WIDTH_IDX_W  = idx_w(RSZ_IMG_WIDTH_SIZE);
  localparam int RSZ_IMG_HEIGHT_IDX_W = idx_w(RSZ_IMG_HEIGHT_SIZE);

  localparam int BLK_X_SIZE  = SRC_W / RSZ_IMG_WIDTH_SIZE;
  localparam int BLK_Y_SIZE  = SRC_H / RSZ_IMG_HEIGHT_SIZE;
  localparam int BLK_X_IDX_W = idx_w(BLK_X_SIZE);
  localparam int BLK_Y_IDX_W = idx_w(BLK_Y_SIZE);

  // Wide enough for BLK_X*BLK_Y pixels at full scale, so no overflow.
  localparam int BLK_SUM_W = PXL_W + $clog2(BLK_X_SIZE * BLK_Y_SIZE);

  typedef logic [BLK_SUM_W-1:0] blk_sum_t;

endpackage

// File: rtl/img_rsz_blk_acc_pos_cnt.sv
// img_rsz_pos_cnt: raster position tracker for the block accumulator.
// Four nested wrap counters (in-block X, block X, in-block Y, block Y) that
// step once per advance pulse, plus first/last-of-block and last-of-frame flags.
// Ports:
//   clk_i, rst_i   clock, async active-high reset
//   adv_i          advance one pixel position
//   in_blk_x_o     column inside the current block
//   blk_x_o        destination block column
//   in_blk_y_o     row inside the current block
//   blk_y_o        destination block row
//   blk_first_o    current position is the first pixel of its block
//   blk_last_o     current position is the last pixel of its block
//   frm_last_o     current position is the last pixel of the frame
module img_rsz_pos_cnt
  import ImgRszPkg::*;
(
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            adv_i,
  output logic [BLK_X_IDX_W-1:0]          in_blk_x_o,
  output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  blk_x_o,
  output logic [BLK_Y_IDX_W-1:0]          in_blk_y_o,
  output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] blk_y_o,
  output logic                            blk_first_o,
  output logic                            blk_last_o,
  output logic                            frm_last_o
);

  localparam logic [BLK_X_IDX_W-1:0]          IN_X_MAX  = BLK_X_IDX_W'(BLK_X_SIZE - 1);
  localparam logic [RSZ_IMG_WIDTH_IDX_W-1:0]  BLK_X_MAX = RSZ_IMG_WIDTH_IDX_W'(RSZ_IMG_WIDTH_SIZE - 1);
  localparam logic [BLK_Y_IDX_W-1:0]          IN_Y_MAX  = BLK_Y_IDX_W'(BLK_Y_SIZE - 1);
  localparam logic [RSZ_IMG_HEIGHT_IDX_W-1:0] BLK_Y_MAX = RSZ_IMG_HEIGHT_IDX_W'(RSZ_IMG_HEIGHT_SIZE - 1);

  logic [BLK_X_IDX_W-1:0]          in_x_q, in_x_d;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  blk_x_q, blk_x_d;
  logic [BLK_Y_IDX_W-1:0]          in_y_q, in_y_d;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] blk_y_q, blk_y_d;
  logic in_x_wrap, blk_x_wrap, in_y_wrap, blk_y_wrap;

  assign in_x_wrap  = (in_x_q  == IN_X_MAX);
  assign blk_x_wrap = (blk_x_q == BLK_X_MAX);
  assign in_y_wrap  = (in_y_q  == IN_Y_MAX);
  assign blk_y_wrap = (blk_y_q == BLK_Y_MAX);

  // Each counter steps only when every inner counter wraps on this advance.
  always_comb begin
    in_x_d  = in_x_q;
    blk_x_d = blk_x_q;
    in_y_d  = in_y_q;
    blk_y_d = blk_y_q;
    if (adv_i) begin
      in_x_d = in_x_wrap ? '0 : in_x_q + 1'b1;
      if (in_x_wrap) begin
        blk_x_d = blk_x_wrap ? '0 : blk_x_q + 1'b1;
        if (blk_x_wrap) begin
          in_y_d = in_y_wrap ? '0 : in_y_q + 1'b1;
          if (in_y_wrap) begin
            blk_y_d = blk_y_wrap ? '0 : blk_y_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      in_x_q  <= '0;
      blk_x_q <= '0;
      in_y_q  <= '0;
      blk_y_q <= '0;
    end else begin
      in_x_q  <= in_x_d;
      blk_x_q <= blk_x_d;
      in_y_q  <= in_y_d;
      blk_y_q <= blk_y_d;
    end
  end

  assign in_blk_x_o  = in_x_q;
  assign blk_x_o     = blk_x_q;
  assign in_blk_y_o  = in_y_q;
  assign blk_y_o     = blk_y_q;
  assign blk_first_o = (in_x_q == '0) && (in_y_q == '0);
  assign blk_last_o  = in_x_wrap && in_y_wrap;
  assign frm_last_o  = in_x_wrap && blk_x_wrap && in_y_wrap && blk_y_wrap;

endmodule

// File: rtl/img_rsz_blk_acc.sv
// img_rsz_blk_acc: per-block pixel sum accumulator for the image resizer.
// Maps each raster-order source pixel to its destination block, accumulates
// the block sum, flags complete blocks (BlkIsEnough) for the compute stage,
// serves the selected block sum and clears flags on serializer flush.
// Ports:
//   Clk_i, Reset_i        clock, async active-high reset
//   PxlData_i/Vld_i/Rdy_o source pixel stream handshake
//   FrmDone_o             1-cycle pulse after the last pixel of a frame
//   BlkIsEnough_o         [y][x] block complete, awaiting compute
//   CompBlkXMsk_i/YMsk_i  one-hot block selected for flush
//   CompBlkEn_i           flush strobe
//   CompBlkXIdx_i/YIdx_i  block read by the compute stage
//   CompBlkSum_o          sum of the block at (YIdx, XIdx)
module img_rsz_blk_acc
  import ImgRszPkg::*;
(
  input  logic                                                  Clk_i,
  input  logic                                                  Reset_i,
  input  logic [PXL_W-1:0]                                      PxlData_i,
  input  logic                                                  PxlVld_i,
  output logic                                                  PxlRdy_o,
  output logic                                                  FrmDone_o,
  output logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0] BlkIsEnough_o,
  input  logic [RSZ_IMG_WIDTH_SIZE-1:0]                         CompBlkXMsk_i,
  input  logic [RSZ_IMG_HEIGHT_SIZE-1:0]                        CompBlkYMsk_i,
  input  logic                                                  CompBlkEn_i,
  input  logic [RSZ_IMG_WIDTH_IDX_W-1:0]                        CompBlkXIdx_i,
  input  logic [RSZ_IMG_HEIGHT_IDX_W-1:0]                       CompBlkYIdx_i,
  output logic [BLK_SUM_W-1:0]                                  CompBlkSum_o
);

  logic [BLK_X_IDX_W-1:0]          in_blk_x;
  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  blk_x;
  logic [BLK_Y_IDX_W-1:0]          in_blk_y;
  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] blk_y;
  logic blk_first, blk_last, frm_last, accept;

  blk_sum_t sum_q [RSZ_IMG_HEIGHT_SIZE][RSZ_IMG_WIDTH_SIZE];
  blk_sum_t sum_wr_d;
  logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0] enough_q, enough_d, flush_msk;
  logic frm_done_q, frm_done_d;

  img_rsz_pos_cnt u_pos_cnt (
    .clk_i       (Clk_i),
    .rst_i       (Reset_i),
    .adv_i       (accept),
    .in_blk_x_o  (in_blk_x),
    .blk_x_o     (blk_x),
    .in_blk_y_o  (in_blk_y),
    .blk_y_o     (blk_y),
    .blk_first_o (blk_first),
    .blk_last_o  (blk_last),
    .frm_last_o  (frm_last)
  );

  // Stall on a block still holding an unflushed sum; a flush only reopens
  // it after the edge, there is no same-cycle bypass.
  assign PxlRdy_o = ~enough_q[blk_y][blk_x];
  assign accept   = PxlVld_i & PxlRdy_o;

  // First pixel of a block overwrites the stale sum, so flush never clears it.
  assign sum_wr_d = blk_first ? blk_sum_t'(PxlData_i)
                              : sum_q[blk_y][blk_x] + blk_sum_t'(PxlData_i);

  always_comb begin
    flush_msk = '0;
    for (int y = 0; y < RSZ_IMG_HEIGHT_SIZE; y++) begin
      flush_msk[y] = CompBlkYMsk_i[y] ? CompBlkXMsk_i : '0;
    end
  end

  // Flush and completion never target the same block (PxlRdy is low there),
  // so applying both in sequence is order-independent.
  always_comb begin
    enough_d = enough_q;
    if (CompBlkEn_i) begin
      enough_d = enough_d & ~flush_msk;
    end
    if (accept && blk_last) begin
      enough_d[blk_y][blk_x] = 1'b1;
    end
  end

  assign frm_done_d = accept & frm_last;

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      enough_q   <= '0;
      frm_done_q <= 1'b0;
    end else begin
      enough_q   <= enough_d;
      frm_done_q <= frm_done_d;
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      for (int y = 0; y < RSZ_IMG_HEIGHT_SIZE; y++) begin
        for (int x = 0; x < RSZ_IMG_WIDTH_SIZE; x++) begin
          sum_q[y][x] <= '0;
        end
      end
    end else if (accept) begin
      sum_q[blk_y][blk_x] <= sum_wr_d;
    end
  end

  // Row index range is not a power of two; out-of-range rows read as zero.
  assign CompBlkSum_o = (int'(CompBlkYIdx_i) < RSZ_IMG_HEIGHT_SIZE)
                        ? sum_q[CompBlkYIdx_i][CompBlkXIdx_i] : '0;

  assign BlkIsEnough_o = enough_q;
  assign FrmDone_o     = frm_done_q;

endmodule
